// File: rtl/fetch_stage.sv
// fetch_stage: PC, single-outstanding imem port, prefetch FIFO and decode handshake; FETCH_PERF_CNT_EN adds perf counters
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  output logic [15:0] instr,
  output logic [15:0] pc_plus2,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        halted,
  output logic [15:0] fetch_count,
  output logic [15:0] flush_count
);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {RUN, WAIT, FLUSH, DRAIN, HALTED} state_t;

  state_t          state_q, state_d;
  logic [15:0]     pc_q, pc_d;
  logic [15:0]     fifo_instr_q [BUF_DEPTH];
  logic [15:0]     fifo_p2_q [BUF_DEPTH];
  logic [AW-1:0]   wr_q, rd_q;
  logic [CW-1:0]   cnt_q;
  logic            busy, pending, kill, push, pop;

  assign imem_req    = rst_n && state_q == RUN && cnt_q < CW'(BUF_DEPTH);
  assign imem_addr   = pc_q;
  assign instr_valid = cnt_q != '0;
  assign instr       = instr_valid ? fifo_instr_q[rd_q] : 16'h0800;
  assign pc_plus2    = instr_valid ? fifo_p2_q[rd_q] : 16'h0000;
  assign halted      = state_q == HALTED;
  // busy: a request is in flight whose ack has not yet been consumed
  assign busy        = state_q == WAIT || state_q == FLUSH || state_q == DRAIN;
  // pending: an ack will still be owed after this edge
  assign pending     = (busy && !imem_ack) || imem_req;
  assign kill        = (halt && state_q != HALTED) ||
                       (redirect_valid && (state_q == RUN || state_q == WAIT || state_q == FLUSH));
  assign push        = state_q == WAIT && imem_ack && !kill;
  assign pop         = instr_valid && instr_ready && !kill;

  // next state: halt beats redirect, both beat normal request/ack sequencing
  always_comb begin
    state_d = state_q;
    pc_d    = push ? pc_q + 16'd2 : pc_q;
    if (halt && state_q != HALTED)
      state_d = pending ? DRAIN : HALTED;
    else if (kill) begin
      state_d = pending ? FLUSH : RUN;
      pc_d    = redirect_pc & 16'hFFFE;
    end
    else if (state_q == RUN && imem_req)
      state_d = WAIT;
    else if (busy && imem_ack)
      state_d = state_q == DRAIN ? HALTED : RUN;
  end

  // state, pc and FIFO pointers; a redirect or halt empties the FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wr_q    <= kill ? '0 : wr_q + AW'(push);
      rd_q    <= kill ? '0 : rd_q + AW'(pop);
      cnt_q   <= kill ? '0 : cnt_q + CW'(push) - CW'(pop);
    end
  end

  // FIFO storage; contents are only meaningful below the occupancy count
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr_q[wr_q] <= imem_rdata;
      fifo_p2_q[wr_q]    <= pc_q + 16'd2;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_cnt_q, flush_cnt_q;
  logic        squash;

  assign squash      = cnt_q != '0 || state_q == WAIT || imem_req;
  assign fetch_count = fetch_cnt_q;
  assign flush_count = flush_cnt_q;

  // saturating counters of decode pops and effective flushes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_q + 16'(pop && fetch_cnt_q != 16'hFFFF);
      flush_cnt_q <= flush_cnt_q + 16'(kill && squash && flush_cnt_q != 16'hFFFF);
    end
  end
`else
  assign fetch_count = 16'h0000;
  assign flush_count = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage with a variable-latency memory model
module tb_fetch_stage;
  logic        clk = 0, rst_n = 1;
  logic        imem_req, imem_ack = 0;
  logic [15:0] imem_addr, imem_rdata = 0;
  logic        redirect_valid = 0, halt = 0, instr_ready = 0;
  logic [15:0] redirect_pc = 0;
  logic [15:0] instr, pc_plus2, fetch_count, flush_count;
  logic        instr_valid, halted;

  int          checks = 0, errors = 0;
  logic [31:0] exp_q[$];
  logic [15:0] addr_log[$];
  int          lat = 1, cd = 0;
  logic        busy = 0;
  logic [15:0] m_addr = 0;

  fetch_stage #(.RESET_PC(16'h0000), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .halt(halt), .instr(instr), .pc_plus2(pc_plus2),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .halted(halted),
    .fetch_count(fetch_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'h5A3C ^ {a[7:0], a[15:8]};
  endfunction

  // memory: accepts a request seen at negedge, acks lat cycles later for one cycle
  always @(negedge clk) begin
    imem_ack = 0;
    if (!rst_n) busy = 0;
    else if (busy) begin
      cd = cd - 1;
      if (cd == 0) begin
        imem_ack   = 1;
        imem_rdata = mem_word(m_addr);
        busy       = 0;
      end
    end else if (imem_req) begin
      busy   = 1;
      cd     = lat;
      m_addr = imem_addr;
      addr_log.push_back(imem_addr);
    end
  end

  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input int l);
    lat = l;
    rst_n = 0;
    redirect_valid = 0;
    halt = 0;
    instr_ready = 0;
    cycle();
    cycle();
    exp_q.delete();
    rst_n = 1;
  endtask

  task automatic test_reset();
    #1 rst_n = 0;
    cycle();
    cycle();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", imem_req); end
    checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL rst_addr got %h want 0000", imem_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", instr_valid); end
    checks++; if (instr !== 16'h0800) begin errors++; $display("FAIL rst_instr got %h want 0800", instr); end
    checks++; if (pc_plus2 !== 16'h0000) begin errors++; $display("FAIL rst_pcp2 got %h want 0000", pc_plus2); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted got %b want 0", halted); end
    checks++; if (fetch_count !== 16'h0000) begin errors++; $display("FAIL rst_fetch_count got %h want 0000", fetch_count); end
    checks++; if (flush_count !== 16'h0000) begin errors++; $display("FAIL rst_flush_count got %h want 0000", flush_count); end
    rst_n = 1;
  endtask

  task automatic test_stream();
    int base;
    logic [31:0] e;
    logic [15:0] want;
    do_reset(1);
    instr_ready = 1;
    base = addr_log.size();
    for (int a = 0; a < 6; a += 2) exp_q.push_back({mem_word(16'(a)), 16'(a + 2)});
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
      if (instr_valid) begin
        e = exp_q.pop_front();
        checks++;
        if ({instr, pc_plus2} !== e) begin errors++; $display("FAIL stream_out got %h want %h", {instr, pc_plus2}, e); end
      end
      cycle();
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stream_timeout got %0d left want 0", exp_q.size()); end
    for (int k = 0; k < 3; k++) begin
      want = 16'(2 * k);
      checks++;
      if (addr_log.size() <= base + k || addr_log[base + k] !== want) begin
        errors++; $display("FAIL stream_addr%0d got %h want %h", k, (addr_log.size() > base + k) ? addr_log[base + k] : 16'hxxxx, want);
      end
    end
  endtask

  task automatic test_backpressure();
    int base, reqs;
    logic [31:0] e;
    do_reset(1);
    base = addr_log.size();
    reqs = 0;
    for (int i = 0; i < 10; i++) begin
      if (i >= 6 && imem_req) reqs++;
      cycle();
    end
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %b want 1", instr_valid); end
    checks++; if (instr !== mem_word(16'h0000)) begin errors++; $display("FAIL bp_instr got %h want %h", instr, mem_word(16'h0000)); end
    checks++; if (pc_plus2 !== 16'h0002) begin errors++; $display("FAIL bp_pcp2 got %h want 0002", pc_plus2); end
    checks++; if (reqs != 0) begin errors++; $display("FAIL bp_req got %0d want 0", reqs); end
    checks++; if (addr_log.size() - base != 2) begin errors++; $display("FAIL bp_reqcount got %0d want 2", addr_log.size() - base); end
    for (int a = 0; a < 6; a += 2) exp_q.push_back({mem_word(16'(a)), 16'(a + 2)});
    instr_ready = 1;
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
      if (instr_valid) begin
        e = exp_q.pop_front();
        checks++;
        if ({instr, pc_plus2} !== e) begin errors++; $display("FAIL bp_out got %h want %h", {instr, pc_plus2}, e); end
      end
      cycle();
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_timeout got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_redirect();
    int base;
    logic hit;
    logic [31:0] e;
    do_reset(3);
    instr_ready = 1;
    hit = 0;
    for (int a = 0; a < 6; a += 2) exp_q.push_back({mem_word(16'(a)), 16'(a + 2)});
    for (int i = 0; i < 60; i++) begin
      if (instr_valid && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({instr, pc_plus2} !== e) begin errors++; $display("FAIL redir_pre got %h want %h", {instr, pc_plus2}, e); end
      end
      if (imem_req && imem_addr == 16'h0006) begin hit = 1; break; end
      cycle();
    end
    checks++; if (!hit) begin errors++; $display("FAIL redir_wait6 got none want req 0006"); end
    cycle();
    base = addr_log.size();
    redirect_valid = 1;
    redirect_pc = 16'h0041;
    cycle();
    redirect_valid = 0;
    exp_q.delete();
    exp_q.push_back({mem_word(16'h0040), 16'h0042});
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
      if (instr_valid) begin
        e = exp_q.pop_front();
        checks++;
        if ({instr, pc_plus2} !== e) begin errors++; $display("FAIL redir_out got %h want %h", {instr, pc_plus2}, e); end
      end
      cycle();
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL redir_timeout got %0d left want 0", exp_q.size()); end
    checks++;
    if (addr_log.size() <= base || addr_log[base] !== 16'h0040) begin
      errors++; $display("FAIL redir_addr got %h want 0040", (addr_log.size() > base) ? addr_log[base] : 16'hxxxx);
    end
  endtask

  task automatic test_wrap();
    int base;
    logic [31:0] e;
    do_reset(1);
    instr_ready = 1;
    base = addr_log.size();
    redirect_valid = 1;
    redirect_pc = 16'hFFFE;
    cycle();
    redirect_valid = 0;
    exp_q.push_back({mem_word(16'hFFFE), 16'h0000});
    exp_q.push_back({mem_word(16'h0000), 16'h0002});
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
      if (instr_valid) begin
        e = exp_q.pop_front();
        checks++;
        if ({instr, pc_plus2} !== e) begin errors++; $display("FAIL wrap_out got %h want %h", {instr, pc_plus2}, e); end
      end
      cycle();
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_timeout got %0d left want 0", exp_q.size()); end
    checks++;
    if (addr_log.size() <= base + 2 || addr_log[base + 1] !== 16'hFFFE || addr_log[base + 2] !== 16'h0000) begin
      errors++; $display("FAIL wrap_addr got %0d entries want FFFE then 0000", addr_log.size() - base);
    end
  endtask

  task automatic test_halt();
    int reqs, vseen;
    logic hit;
    do_reset(3);
    instr_ready = 1;
    cycle();
    halt = 1;
    redirect_valid = 1;
    redirect_pc = 16'h0100;
    cycle();
    halt = 0;
    redirect_valid = 0;
    hit = 0;
    vseen = 0;
    for (int i = 0; i < 20; i++) begin
      if (instr_valid) vseen++;
      if (halted) begin hit = 1; break; end
      cycle();
    end
    checks++; if (!hit) begin errors++; $display("FAIL halt_wait got 0 want halted 1"); end
    checks++; if (vseen != 0) begin errors++; $display("FAIL halt_drain_valid got %0d want 0", vseen); end
    reqs = 0;
    for (int i = 0; i < 8; i++) begin
      if (imem_req) reqs++;
      if (instr_valid) vseen++;
      cycle();
    end
    checks++; if (reqs != 0) begin errors++; $display("FAIL halt_req got %0d want 0", reqs); end
    checks++; if (vseen != 0) begin errors++; $display("FAIL halt_valid got %0d want 0", vseen); end
    checks++; if (instr !== 16'h0800) begin errors++; $display("FAIL halt_instr got %h want 0800", instr); end
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_stay got %b want 1", halted); end
    @(posedge clk);
    #3 rst_n = 0;
    #1;
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_async_rst got %b want 0", halted); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL halt_rst_req got %b want 0", imem_req); end
    cycle();
  endtask

  task automatic test_perf();
    int pops;
    logic hit;
    logic [31:0] e;
    logic [15:0] want_f, want_fl;
`ifdef FETCH_PERF_CNT_EN
    want_f = 16'd5;
    want_fl = 16'd2;
`else
    want_f = 16'd0;
    want_fl = 16'd0;
`endif
    do_reset(1);
    instr_ready = 1;
    pops = 0;
    for (int a = 0; a < 10; a += 2) exp_q.push_back({mem_word(16'(a)), 16'(a + 2)});
    for (int i = 0; i < 60 && pops < 5; i++) begin
      if (instr_valid) begin
        e = exp_q.pop_front();
        pops++;
        checks++;
        if ({instr, pc_plus2} !== e) begin errors++; $display("FAIL perf_out got %h want %h", {instr, pc_plus2}, e); end
      end
      cycle();
    end
    instr_ready = 0;
    checks++; if (pops != 5) begin errors++; $display("FAIL perf_pops got %0d want 5", pops); end
    for (int r = 0; r < 2; r++) begin
      hit = 0;
      for (int i = 0; i < 20; i++) begin
        if (imem_req || instr_valid) begin hit = 1; break; end
        cycle();
      end
      checks++; if (!hit) begin errors++; $display("FAIL perf_wait%0d got none want req or valid", r); end
      redirect_valid = 1;
      redirect_pc = 16'h0200;
      cycle();
      redirect_valid = 0;
    end
    cycle();
    checks++; if (fetch_count !== want_f) begin errors++; $display("FAIL perf_fetch_count got %0d want %0d", fetch_count, want_f); end
    checks++; if (flush_count !== want_fl) begin errors++; $display("FAIL perf_flush_count got %0d want %0d", flush_count, want_fl); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_halt();
    test_perf();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
